// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader.
// Also provides fallback values for the text-segment macros so the loader
// builds stand-alone when the SoC map header is not part of the compile.
`ifndef TEXT_SEG_BASE
`define TEXT_SEG_BASE 32'h0000_0000
`endif
`ifndef TEXT_SEG_WORDS
`define TEXT_SEG_WORDS 1024
`endif

package boot_pkg;

    // Loader states; the encoding is visible on the debug port.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CSUM  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } boot_state_e;

    // First byte of every image.
    localparam logic [7:0] BOOT_MAGIC = 8'hA5;

    // Bytes per assembled word.
    localparam int BOOT_LANES = 4;

    // Byte address of text word idx.
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [31:0] idx);
        return base + {idx[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/bus_pkg.sv
// Data-bus master/slave struct types shared by the boot loader and the
// text RAM. One request in flight at a time; the slave answers with ack.
package bus;

    // Master-to-slave request.
    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } m2s_s;

    // Slave-to-master response.
    typedef struct packed {
        logic        ack;
        logic [31:0] rdata;
    } s2m_s;

endpackage

// File: rtl/boot_word_asm.sv
// Little-endian byte-to-word assembler. Byte k of a word lands in bits
// 8k+7:8k. word_next is the word including the byte presented this cycle,
// so the consumer can capture a finished word on the same edge that the
// last byte is sampled (word_ready high).
module boot_word_asm
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst_b,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word_next,
    output logic        word_ready
);

    localparam int CW = $clog2(BOOT_LANES);

    logic [CW-1:0] byte_cnt_q, byte_cnt_d;
    logic [31:0]   asm_q, asm_d;

    // Merge the incoming byte into its lane and advance the lane counter.
    always_comb begin
        word_next = asm_q;
        word_next[8*byte_cnt_q +: 8] = byte_data;
        word_ready = byte_valid && (byte_cnt_q == CW'(BOOT_LANES - 1));
        asm_d = asm_q;
        byte_cnt_d = byte_cnt_q;
        if (clear) begin
            asm_d = '0;
            byte_cnt_d = '0;
        end else if (byte_valid) begin
            asm_d = word_next;
            byte_cnt_d = byte_cnt_q + CW'(1);
        end
    end

    // Assembly register and lane counter.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            asm_q <= '0;
            byte_cnt_q <= '0;
        end else begin
            asm_q <= asm_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

endmodule

// File: rtl/boot_loader_bus.sv
// UART boot loader: parses magic / length / payload (/ checksum), writes the
// payload words to the text segment and releases the core when complete.
// Optional feature macro: BOOT_CSUM_EN adds the trailing checksum byte check.
//
// Bus handshake: bus_o.valid rises the cycle after a word completes, address
// and data stay constant until bus_i.ack is sampled high, and valid drops in
// the following cycle. A new request never starts in the same cycle an older
// one completes, so consecutive requests are separated by an idle cycle.
module boot_loader_bus
    import boot_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = `TEXT_SEG_BASE,
    parameter int          MAX_WORDS      = `TEXT_SEG_WORDS,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output bus::m2s_s   bus_o,
    input  bus::s2m_s   bus_i,
    output logic        core_rst_b,
    output logic        done,
    output logic        error,
    output logic [2:0]  dbg_state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    boot_state_e  state_q, state_d;
    logic         req_q, req_d;
    logic [31:0]  wdata_q, wdata_d;
    logic [31:0]  idx_q, idx_d;       // words acknowledged
    logic [31:0]  wcnt_q, wcnt_d;     // payload words assembled
    logic [31:0]  len_q, len_d;
    logic [TW-1:0] idle_q, idle_d;
    logic         errp_q, errp_d;     // fault seen while a request is pending
    logic         done_q, done_d;
    logic         error_q, error_d;
`ifdef BOOT_CSUM_EN
    logic [7:0]   csum_q, csum_d;
    logic [7:0]   csh_q, csh_d;       // checksum byte that arrived before the last ack
    logic         csh_have_q, csh_have_d;
`endif

    logic         asm_clear;
    logic         asm_valid;
    logic [31:0]  word_next;
    logic         word_ready;
    logic         is_magic;
    logic         payload_open;
    logic         active;
    logic         timeout_hit;
    logic         ack;
    logic         restart;
    logic         unused_rdata;

    assign unused_rdata = ^bus_i.rdata;

    assign is_magic     = rx_valid && (rx_data == BOOT_MAGIC);
    assign payload_open = (wcnt_q < len_q);
    assign active       = (state_q == ST_LEN) || (state_q == ST_DATA) ||
                          (state_q == ST_WRITE) || (state_q == ST_CSUM);
    assign timeout_hit  = active && !rx_valid && (idle_q == TO_LAST);
    assign ack          = req_q && bus_i.ack;
    assign restart      = is_magic && ((state_q == ST_IDLE) || (state_q == ST_ERR));

    // Bytes reach the assembler for the length field and for payload only;
    // anything after the last payload byte (or after a fault) is kept out.
    assign asm_valid = rx_valid &&
                       ((state_q == ST_LEN) ||
                        (((state_q == ST_DATA) || (state_q == ST_WRITE)) &&
                         payload_open && !errp_q));

    boot_word_asm u_asm (
        .clk        (clk),
        .rst_b      (rst_b),
        .clear      (asm_clear),
        .byte_valid (asm_valid),
        .byte_data  (rx_data),
        .word_next  (word_next),
        .word_ready (word_ready)
    );

    // Inter-byte idle counter; saturates so a held fault stays asserted.
    always_comb begin
        if (!active || rx_valid) begin
            idle_d = '0;
        end else if (idle_q != TO_LAST) begin
            idle_d = idle_q + TW'(1);
        end else begin
            idle_d = idle_q;
        end
    end

    // Loader FSM, bus handshake and payload bookkeeping.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        wdata_d   = wdata_q;
        idx_d     = idx_q;
        wcnt_d    = wcnt_q;
        len_d     = len_q;
        errp_d    = errp_q;
        asm_clear = 1'b0;
`ifdef BOOT_CSUM_EN
        csum_d     = csum_q;
        csh_d      = csh_q;
        csh_have_d = csh_have_q;
        if (asm_valid && (state_q != ST_LEN)) begin
            csum_d = csum_q + rx_data;
        end
`endif

        case (state_q)
            ST_IDLE: begin
                // Non-magic bytes are dropped; magic handled by restart below.
            end

            ST_LEN: begin
                if (word_ready) begin
                    len_d = word_next;
                    if (word_next > 32'(MAX_WORDS)) begin
                        state_d = ST_ERR;
                    end else if (word_next == 32'd0) begin
`ifdef BOOT_CSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_ERR;
                end
            end

            ST_DATA: begin
                if (word_ready) begin
                    wdata_d = word_next;
                    wcnt_d  = wcnt_q + 32'd1;
                    req_d   = 1'b1;
                    state_d = ST_WRITE;
                end else if (timeout_hit) begin
                    state_d = ST_ERR;
                end
            end

            ST_WRITE: begin
`ifdef BOOT_CSUM_EN
                if (rx_valid && !payload_open && !csh_have_q) begin
                    csh_d      = rx_data;
                    csh_have_d = 1'b1;
                end
`endif
                if (word_ready) begin
                    wcnt_d = wcnt_q + 32'd1;
                end
                if (req_q) begin
                    if (ack) begin
                        idx_d = idx_q + 32'd1;
                        req_d = 1'b0;
                        if (errp_q || timeout_hit) begin
                            state_d = ST_ERR;
                        end else if (idx_q + 32'd1 == len_q) begin
`ifdef BOOT_CSUM_EN
                            if (csh_have_q) begin
                                state_d = (csh_q == csum_q) ? ST_DONE : ST_ERR;
                            end else if (rx_valid) begin
                                state_d = (rx_data == csum_q) ? ST_DONE : ST_ERR;
                            end else begin
                                state_d = ST_CSUM;
                            end
`else
                            state_d = ST_DONE;
`endif
                        end else if (word_ready) begin
                            // Next word finished on the ack edge: keep WRITE,
                            // the cleared req gives the idle cycle.
                            wdata_d = word_next;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else if (timeout_hit || word_ready) begin
                        // Overrun or timeout: let the pending write finish first.
                        errp_d = 1'b1;
                    end
                end else begin
                    if (timeout_hit || word_ready) begin
                        state_d = ST_ERR;
                    end else begin
                        req_d = 1'b1;
                    end
                end
            end

            ST_CSUM: begin
`ifdef BOOT_CSUM_EN
                if (rx_valid) begin
                    state_d = (rx_data == csum_q) ? ST_DONE : ST_ERR;
                end else if (timeout_hit) begin
                    state_d = ST_ERR;
                end
`else
                state_d = ST_ERR;
`endif
            end

            ST_DONE: begin
                // Terminal until reset.
            end

            ST_ERR: begin
                // Only a magic byte leaves ERR, handled by restart below.
            end

            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase

        if (restart) begin
            state_d   = ST_LEN;
            req_d     = 1'b0;
            idx_d     = '0;
            wcnt_d    = '0;
            len_d     = '0;
            errp_d    = 1'b0;
            asm_clear = 1'b1;
`ifdef BOOT_CSUM_EN
            csum_d     = '0;
            csh_have_d = 1'b0;
`endif
        end
    end

    // Status outputs follow the state one cycle later.
    always_comb begin
        done_d  = (state_q == ST_DONE);
        error_d = (state_q == ST_ERR);
    end

    // Bus request is built only from registered state so it is glitch-free.
    always_comb begin
        bus_o       = '0;
        bus_o.valid = req_q;
        bus_o.write = 1'b1;
        bus_o.addr  = word_addr(BASE_ADDR, idx_q);
        bus_o.data  = wdata_q;
        bus_o.be    = 4'hF;
    end

    assign done       = done_q;
    assign error      = error_q;
    assign core_rst_b = done_q;
    assign dbg_state  = state_q;

    // Loader state registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            wdata_q <= '0;
            idx_q   <= '0;
            wcnt_q  <= '0;
            len_q   <= '0;
            idle_q  <= '0;
            errp_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            len_q   <= len_d;
            idle_q  <= idle_d;
            errp_q  <= errp_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

`ifdef BOOT_CSUM_EN
    // Checksum accumulator and early-arriving checksum byte.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            csum_q     <= '0;
            csh_q      <= '0;
            csh_have_q <= 1'b0;
        end else begin
            csum_q     <= csum_d;
            csh_q      <= csh_d;
            csh_have_q <= csh_have_d;
        end
    end
`endif

endmodule
